// File: rtl/mundo_seq_if.sv
// Handshake and status bundle between the level sequencer and its environment.
// slave = sequencer side, master = game/matcher side.
interface mundo_seq_if #(
  parameter int W     = 19,
  parameter int LVL_W = 2,
  parameter int TRY_W = 2
);
  logic             i_start;
  logic             i_check;
  logic [W-1:0]     i_sw;
  logic             i_hit;
  logic [W-1:0]     o_word_q;
  logic [LVL_W-1:0] o_level;
  logic [TRY_W-1:0] o_attempts;
  logic             o_pass_led;
  logic             o_fail_led;
  logic             o_win;
  logic             o_lose;
  logic             o_busy;

  modport slave (
    input  i_start, i_check, i_sw, i_hit,
    output o_word_q, o_level, o_attempts, o_pass_led, o_fail_led, o_win, o_lose, o_busy
  );

  modport master (
    output i_start, i_check, i_sw, i_hit,
    input  o_word_q, o_level, o_attempts, o_pass_led, o_fail_led, o_win, o_lose, o_busy
  );
endinterface

// File: rtl/mundo_seq.sv
// Level sequencer: latches switches on check, grades via external hit, holds pass/fail LEDs.
// check->LED in 3 cycles; no backpressure, start/check outside accepting states are dropped.
module mundo_seq #(
  parameter int W         = 19,
  parameter int LEVELS    = 4,
  parameter int LVL_W     = 2,
  parameter int MAX_TRIES = 3,
  parameter int TRY_W     = 2,
  parameter int HOLD_CYC  = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mundo_seq_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LATCH, S_EVAL, S_PASS, S_FAIL, S_WIN, S_LOSE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_word;
  logic [LVL_W-1:0] r_level;
  logic [TRY_W-1:0] r_tries;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hold_done;
  logic             w_last_lvl;

  assign w_hold_done = (r_cnt == CNT_W'(HOLD_CYC - 1));
  assign w_last_lvl  = (r_level == LVL_W'(LEVELS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_level <= '0;
      r_tries <= TRY_W'(MAX_TRIES);
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (bus.i_start) begin
            r_level <= '0;
            r_tries <= TRY_W'(MAX_TRIES);
          end
        end
        S_ARM: begin
          // start beats a coincident check, so the word is not relatched on restart
          if (bus.i_start) begin
            r_level <= '0;
            r_tries <= TRY_W'(MAX_TRIES);
          end else if (bus.i_check) begin
            r_word <= bus.i_sw;
          end
        end
        S_EVAL: begin
          r_cnt <= '0;
          if (!bus.i_hit) r_tries <= r_tries - 1'b1;
        end
        S_PASS: begin
          if (!w_hold_done) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_last_lvl) begin
            r_level <= r_level + 1'b1;
            r_tries <= TRY_W'(MAX_TRIES);
          end
        end
        S_FAIL: begin
          if (!w_hold_done) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_ARM;
      S_ARM: begin
        if (bus.i_start)      w_next = S_ARM;
        else if (bus.i_check) w_next = S_LATCH;
      end
      S_LATCH: w_next = S_EVAL;
      S_EVAL:  w_next = bus.i_hit ? S_PASS : S_FAIL;
      S_PASS:  if (w_hold_done) w_next = w_last_lvl ? S_WIN : S_ARM;
      S_FAIL:  if (w_hold_done) w_next = (r_tries == '0) ? S_LOSE : S_ARM;
      S_WIN, S_LOSE: if (bus.i_start) w_next = S_ARM;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_pass_led = 1'b0;
    bus.o_fail_led = 1'b0;
    bus.o_win      = 1'b0;
    bus.o_lose     = 1'b0;
    bus.o_busy     = 1'b0;
    case (r_state)
      S_LATCH, S_EVAL: bus.o_busy = 1'b1;
      S_PASS: begin
        bus.o_pass_led = 1'b1;
        bus.o_busy     = 1'b1;
      end
      S_FAIL: begin
        bus.o_fail_led = 1'b1;
        bus.o_busy     = 1'b1;
      end
      S_WIN:   bus.o_win  = 1'b1;
      S_LOSE:  bus.o_lose = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_word_q   = r_word;
  assign bus.o_level    = r_level;
  assign bus.o_attempts = r_tries;
endmodule

// File: tb/tb_mundo_seq.sv
// Directed bench for mundo_seq: vector table for reset and first PASS, hand sequences for
// fail/lose, full win, restart priority, ignored check and mid-hold reset.
module tb_mundo_seq;
  localparam int HOLD = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mundo_seq_if #(.W(19), .LVL_W(2), .TRY_W(2)) bus ();

  mundo_seq #(
    .W(19), .LEVELS(4), .LVL_W(2), .MAX_TRIES(3), .TRY_W(2), .HOLD_CYC(HOLD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, start, check, hit;
    logic [18:0] sw;
    logic [18:0] wq;
    logic [1:0]  lvl, att;
    logic        pass, fail, win, lose, busy;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic r, input logic st, input logic ck, input logic h,
                              input logic [18:0] s, input logic [18:0] wq,
                              input logic [1:0] lvl, input logic [1:0] att,
                              input logic p, input logic f, input logic busy);
    vec_t v;
    v.rst = r; v.start = st; v.check = ck; v.hit = h; v.sw = s;
    v.wq = wq; v.lvl = lvl; v.att = att; v.pass = p; v.fail = f;
    v.win = 1'b0; v.lose = 1'b0; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_status(input string nm, input logic [1:0] lvl, input logic [1:0] att,
                            input logic win, input logic lose, input logic busy);
    chk({nm, ".level"},    32'(bus.o_level),    32'(lvl));
    chk({nm, ".attempts"}, 32'(bus.o_attempts), 32'(att));
    chk({nm, ".win"},      32'(bus.o_win),      32'(win));
    chk({nm, ".lose"},     32'(bus.o_lose),     32'(lose));
    chk({nm, ".busy"},     32'(bus.o_busy),     32'(busy));
  endtask

  // One attempt from ARM: check, settle, evaluate, full hold; optional check poke mid-hold.
  task automatic play(input string nm, input logic [18:0] s, input logic h, input logic poke);
    bus.i_check = 1'b1;
    bus.i_sw    = s;
    step();
    bus.i_check = 1'b0;
    chk({nm, ".latch_wq"},   32'(bus.o_word_q), 32'(s));
    chk({nm, ".latch_busy"}, 32'(bus.o_busy),   32'd1);
    bus.i_hit = h;
    step();
    chk({nm, ".eval_led"}, 32'({bus.o_pass_led, bus.o_fail_led}), 32'd0);
    step();
    bus.i_hit = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      chk({nm, ".hold_pass"}, 32'(bus.o_pass_led), 32'(h));
      chk({nm, ".hold_fail"}, 32'(bus.o_fail_led), 32'(!h));
      if (poke && i == 1) begin
        bus.i_check = 1'b1;
        bus.i_sw    = 19'h55555;
      end
      step();
      bus.i_check = 1'b0;
    end
    chk({nm, ".after_led"}, 32'({bus.o_pass_led, bus.o_fail_led}), 32'd0);
    chk({nm, ".after_wq"},  32'(bus.o_word_q), 32'(s));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_check = 1'b0;
    bus.i_sw    = '0;
    bus.i_hit   = 1'b0;

    //           rst   st    ck    hit   sw         wq         lvl   att    p     f     busy
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 19'h0,     19'h0,     2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 19'h0,     19'h0,     2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 19'h215DB, 19'h0,     2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 19'h215DB, 19'h0,     2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 19'h215DB, 19'h215DB, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 19'h215DB, 19'h215DB, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 19'h0,     19'h215DB, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     19'h215DB, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     19'h215DB, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     19'h215DB, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     19'h215DB, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      rst         = tbl[i].rst;
      bus.i_start = tbl[i].start;
      bus.i_check = tbl[i].check;
      bus.i_hit   = tbl[i].hit;
      bus.i_sw    = tbl[i].sw;
      step();
      chk($sformatf("vec%0d.word_q", i),   32'(bus.o_word_q),   32'(tbl[i].wq));
      chk($sformatf("vec%0d.pass_led", i), 32'(bus.o_pass_led), 32'(tbl[i].pass));
      chk($sformatf("vec%0d.fail_led", i), 32'(bus.o_fail_led), 32'(tbl[i].fail));
      chk_status($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].att, tbl[i].win, tbl[i].lose,
                 tbl[i].busy);
    end
    bus.i_start = 1'b0;
    bus.i_check = 1'b0;
    bus.i_hit   = 1'b0;

    // three misses at level 1 exhaust the attempts
    play("miss1", 19'h00011, 1'b0, 1'b0);
    chk_status("miss1", 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    play("miss2", 19'h00022, 1'b0, 1'b0);
    chk_status("miss2", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    play("miss3", 19'h00033, 1'b0, 1'b0);
    chk_status("miss3", 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.i_check = 1'b1;
    bus.i_sw    = 19'h7FFFF;
    step();
    bus.i_check = 1'b0;
    step();
    chk_status("lose_chk", 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("lose_chk.word_q", 32'(bus.o_word_q), 32'h00033);

    // clear all four levels
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk_status("restart1", 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 4; l++) begin
      play($sformatf("win_l%0d", l), 19'h3FFFF, 1'b1, 1'b0);
      if (l < 3) chk_status($sformatf("win_l%0d", l), 2'(l + 1), 2'd3, 1'b0, 1'b0, 1'b0);
      else       chk_status("win_final", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_status("win_sticky", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk_status("restart2", 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);

    // miss then pass with a check poked during PASS; then start+check together
    play("prio_miss", 19'h01234, 1'b0, 1'b0);
    chk_status("prio_miss", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    play("poke", 19'h0AAAA, 1'b1, 1'b1);
    chk_status("poke", 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    play("prio_miss2", 19'h0BBBB, 1'b0, 1'b0);
    chk_status("prio_miss2", 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    bus.i_start = 1'b1;
    bus.i_check = 1'b1;
    bus.i_sw    = 19'h11111;
    step();
    bus.i_start = 1'b0;
    bus.i_check = 1'b0;
    chk_status("start_check", 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("start_check.word_q", 32'(bus.o_word_q), 32'h0BBBB);

    // reset in the middle of a PASS hold at level 1
    play("pre_rst", 19'h0CCCC, 1'b1, 1'b0);
    chk_status("pre_rst", 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    bus.i_check = 1'b1;
    bus.i_sw    = 19'h0DDDD;
    step();
    bus.i_check = 1'b0;
    bus.i_hit   = 1'b1;
    step();
    step();
    bus.i_hit = 1'b0;
    chk("mid_rst.in_pass", 32'(bus.o_pass_led), 32'd1);
    step();
    step();
    chk("mid_rst.still_pass", 32'(bus.o_pass_led), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst.pass_led", 32'(bus.o_pass_led), 32'd0);
    chk("mid_rst.word_q",   32'(bus.o_word_q),   32'd0);
    chk_status("mid_rst", 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    chk_status("post_rst_idle", 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
